// File: rtl/pushbutton_processor_multi.sv
// Multi-channel pushbutton front end: synchronise, debounce and classify each press
// into a short pulse, or a long pulse followed by optional auto-repeat pulses.
module pushbutton_processor_multi #(
  parameter int N_CH        = 2,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 2000,
  parameter int REPEAT_MS   = 250
) (
  input  logic            clk_1khz,
  input  logic            rst_i,
  input  logic [N_CH-1:0] pushbutton_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] short_o,
  output logic [N_CH-1:0] long_o,
  output logic [N_CH-1:0] repeat_o
);

  localparam int DB_W   = $clog2(DEBOUNCE_MS + 1);
  localparam int HOLD_W = $clog2(LONG_MS + 1);
  localparam int REP_W  = (REPEAT_MS > 0) ? $clog2(REPEAT_MS + 1) : 1;
  localparam bit REP_EN = (REPEAT_MS > 0);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_MS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_MS);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_MS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } state_t;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic              sync_a;
    logic              sync_b;
    logic              level_q;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic              short_q;
    logic              long_q;
    logic              rep_q;
    logic              toggle;
    state_t            state;

    // level_q flips on this edge; lets the FSM act in the same cycle as the level change
    assign toggle = (sync_b != level_q) && (db_cnt == DB_LAST);

    always_ff @(posedge clk_1khz) begin
      if (rst_i) begin
        sync_a   <= 1'b0;
        sync_b   <= 1'b0;
        level_q  <= 1'b0;
        db_cnt   <= '0;
        hold_cnt <= '0;
        rep_cnt  <= '0;
        short_q  <= 1'b0;
        long_q   <= 1'b0;
        rep_q    <= 1'b0;
        state    <= IDLE;
      end else begin
        sync_a <= pushbutton_i[i];
        sync_b <= sync_a;

        if (sync_b == level_q) begin
          db_cnt <= '0;
        end else if (toggle) begin
          db_cnt  <= '0;
          level_q <= ~level_q;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end

        if (toggle && !level_q) begin
          hold_cnt <= '0;
        end else if (level_q && hold_cnt != HOLD_MAX) begin
          hold_cnt <= hold_cnt + 1'b1;
        end

        short_q <= 1'b0;
        long_q  <= 1'b0;
        rep_q   <= 1'b0;

        case (state)
          IDLE: begin
            if (toggle && !level_q) state <= PRESSED;
          end
          PRESSED: begin
            if (!level_q) begin
              short_q <= 1'b1;
              state   <= toggle ? PRESSED : IDLE;
            end else if (hold_cnt == HOLD_LAST) begin
              long_q  <= 1'b1;
              rep_cnt <= '0;
              state   <= HELD;
            end
          end
          HELD: begin
            if (!level_q) begin
              state <= toggle ? PRESSED : IDLE;
            end else if (toggle) begin
              state <= IDLE;
            end else if (REP_EN) begin
              if (rep_cnt == REP_LAST) begin
                rep_q   <= 1'b1;
                rep_cnt <= '0;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end

    assign level_o[i]  = level_q;
    assign short_o[i]  = short_q;
    assign long_o[i]   = long_q;
    assign repeat_o[i] = rep_q;
  end

endmodule

// File: tb/tb_pushbutton_processor_multi.sv
// Directed bench for pushbutton_processor_multi: a default build plus a repeat-disabled build.
module tb_pushbutton_processor_multi;

  logic       clk_1khz = 1'b0;
  logic       rst_i;
  logic [1:0] d_btn, d_level, d_short, d_long, d_rep;
  logic [1:0] nr_btn, nr_level, nr_short, nr_long, nr_rep;

  pushbutton_processor_multi dut (
    .clk_1khz    (clk_1khz),
    .rst_i       (rst_i),
    .pushbutton_i(d_btn),
    .level_o     (d_level),
    .short_o     (d_short),
    .long_o      (d_long),
    .repeat_o    (d_rep)
  );

  pushbutton_processor_multi #(.REPEAT_MS(0)) dut_norep (
    .clk_1khz    (clk_1khz),
    .rst_i       (rst_i),
    .pushbutton_i(nr_btn),
    .level_o     (nr_level),
    .short_o     (nr_short),
    .long_o      (nr_long),
    .repeat_o    (nr_rep)
  );

  always #5 clk_1khz = ~clk_1khz;

  int cyc = 0;
  always @(posedge clk_1khz) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // index 0/1 = default build ch0/ch1, 2/3 = repeat-disabled build ch0/ch1
  logic [3:0] all_s, all_l, all_r, all_lv;
  logic [3:0] prev_lv = '0;
  assign all_s  = {nr_short, d_short};
  assign all_l  = {nr_long, d_long};
  assign all_r  = {nr_rep, d_rep};
  assign all_lv = {nr_level, d_level};

  int n_s[4], n_l[4], n_r[4], n_rise[4];
  int short_cyc[4], long_cyc[4], rise_cyc[4], first_rep[4], last_rep[4];
  int excl_err = 0;

  always @(negedge clk_1khz) begin
    for (int k = 0; k < 4; k++) begin
      if (all_s[k]) begin n_s[k]++; short_cyc[k] = cyc; end
      if (all_l[k]) begin n_l[k]++; long_cyc[k] = cyc; end
      if (all_r[k]) begin
        if (n_r[k] == 0) first_rep[k] = cyc;
        n_r[k]++;
        last_rep[k] = cyc;
      end
      if (all_lv[k] && !prev_lv[k]) begin n_rise[k]++; rise_cyc[k] = cyc; end
      if (int'(all_s[k]) + int'(all_l[k]) + int'(all_r[k]) > 1) excl_err++;
    end
    prev_lv = all_lv;
  end

  task automatic clear_stats();
    for (int k = 0; k < 4; k++) begin
      n_s[k] = 0; n_l[k] = 0; n_r[k] = 0; n_rise[k] = 0;
      short_cyc[k] = 0; long_cyc[k] = 0; rise_cyc[k] = 0;
      first_rep[k] = 0; last_rep[k] = 0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk_1khz);
  endtask

  int p, r;

  initial begin
    rst_i  = 1'b1;
    d_btn  = '0;
    nr_btn = '0;
    clear_stats();
    wait_cyc(3);
    chk("rst_level", int'(d_level), 0);
    chk("rst_pulses", int'({d_short, d_long, d_rep}), 0);
    chk("rst_norep", int'({nr_level, nr_short, nr_long, nr_rep}), 0);
    rst_i = 1'b0;
    wait_cyc(5);

    // 1: bouncy press, 30 ms hold -> one short pulse
    clear_stats();
    d_btn[0] = 1'b1; wait_cyc(2);
    d_btn[0] = 1'b0; wait_cyc(1);
    d_btn[0] = 1'b1; wait_cyc(2);
    d_btn[0] = 1'b0; wait_cyc(1);
    d_btn[0] = 1'b1; p = cyc;
    wait_cyc(30);
    chk("t1_level_high", int'(d_level[0]), 1);
    d_btn[0] = 1'b0; r = cyc;
    wait_cyc(60);
    chk("t1_rise_lat", rise_cyc[0] - p, 22);
    chk("t1_rises", n_rise[0], 1);
    chk("t1_short", n_s[0], 1);
    chk("t1_short_lat", short_cyc[0] - r, 23);
    chk("t1_long", n_l[0], 0);
    chk("t1_level_end", int'(d_level[0]), 0);

    // 2: repeat-disabled build, 2130 ms hold, bouncy release
    clear_stats();
    nr_btn[0] = 1'b1; p = cyc;
    wait_cyc(2130);
    nr_btn[0] = 1'b0; wait_cyc(1);
    nr_btn[0] = 1'b1; wait_cyc(2);
    nr_btn[0] = 1'b0; wait_cyc(1);
    nr_btn[0] = 1'b1; wait_cyc(1);
    nr_btn[0] = 1'b0;
    wait_cyc(60);
    chk("t2_long", n_l[2], 1);
    chk("t2_long_lat", long_cyc[2] - p, 2022);
    chk("t2_short", n_s[2], 0);
    chk("t2_repeat", n_r[2], 0);
    chk("t2_rises", n_rise[2], 1);
    chk("t2_level_end", int'(nr_level[0]), 0);

    // 3: default build ch1 held 2800 ms -> long + 3 repeats
    clear_stats();
    d_btn[1] = 1'b1; p = cyc;
    wait_cyc(2800);
    d_btn[1] = 1'b0;
    wait_cyc(300);
    chk("t3_long", n_l[1], 1);
    chk("t3_long_lat", long_cyc[1] - p, 2022);
    chk("t3_repeat", n_r[1], 3);
    chk("t3_first_rep", first_rep[1] - long_cyc[1], 250);
    chk("t3_last_rep", last_rep[1] - long_cyc[1], 750);
    chk("t3_short", n_s[1], 0);
    chk("t3_ch0_quiet", n_s[0] + n_l[0] + n_r[0] + n_rise[0], 0);

    // 4: ch0 short press nested inside ch1 long press
    clear_stats();
    d_btn[1] = 1'b1; p = cyc;
    wait_cyc(100);
    d_btn[0] = 1'b1;
    wait_cyc(50);
    d_btn[0] = 1'b0;
    wait_cyc(1950);
    d_btn[1] = 1'b0;
    wait_cyc(60);
    chk("t4_ch0_short", n_s[0], 1);
    chk("t4_ch0_long", n_l[0] + n_r[0], 0);
    chk("t4_ch1_long", n_l[1], 1);
    chk("t4_ch1_long_lat", long_cyc[1] - p, 2022);
    chk("t4_ch1_short_rep", n_s[1] + n_r[1], 0);

    // 5: reset pulse 1000 ms into a held press
    clear_stats();
    d_btn[0] = 1'b1;
    wait_cyc(1000);
    chk("t5_level_pre", int'(d_level[0]), 1);
    rst_i = 1'b1;
    wait_cyc(1);
    chk("t5_rst_level", int'(d_level), 0);
    chk("t5_rst_pulses", int'({d_short, d_long, d_rep}), 0);
    wait_cyc(4);
    chk("t5_rst_hold", int'({d_level, d_short, d_long, d_rep}), 0);
    rst_i = 1'b0; r = cyc;
    wait_cyc(2100);
    d_btn[0] = 1'b0;
    wait_cyc(60);
    chk("t5_rise_lat", rise_cyc[0] - r, 22);
    chk("t5_long", n_l[0], 1);
    chk("t5_long_lat", long_cyc[0] - r, 2022);
    chk("t5_short", n_s[0], 0);

    // 6: 15 ms glitch on idle ch1
    clear_stats();
    d_btn[1] = 1'b1;
    wait_cyc(15);
    d_btn[1] = 1'b0;
    wait_cyc(40);
    chk("t6_rises", n_rise[1], 0);
    chk("t6_pulses", n_s[1] + n_l[1] + n_r[1], 0);
    chk("t6_level", int'(d_level[1]), 0);

    chk("exclusive", excl_err, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
